mul_result_stage: RTL and testbench
===================================

# mul_result_stage

Registered output stage placed directly after the bfloat16 multiplier (`mul_round`). It accepts each product with its exception and class flags over a valid/ready handshake and buffers it in a 2-entry skid buffer, so downstream back-pressure never creates a combinational path to the multiplier. It quiets signalling-NaN results, accumulates sticky IEEE exception flags, and keeps saturating result statistics for the datapath controller.

## Interface
- `CNT_W`, 16: width of each statistics counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream product valid.
- `in_ready`  out  1  stage can accept; a driven register, not combinational from `out_ready`.
- `in_p`  in  16  bfloat16 product.
- `in_exc`  in  4  {overflow, underflow, invalid, inexact}.
- `in_cls`  in  6  {sNaN, qNaN, subnormal, normal, inf, zero}.
- `out_valid`  out  1  downstream data valid.
- `out_ready`  in  1  downstream accepts.
- `out_p`  out  16  buffered product, after quieting.
- `out_exc`  out  4  buffered exception flags.
- `out_cls`  out  6  buffered class flags, after quieting.
- `clr_stat`  in  1  clears the sticky flags and all counters.
- `sticky_exc`  out  4  OR of `in_exc` over every accepted product since the last clear.
- `cnt_total`  out  CNT_W  count of accepted products.
- `cnt_nan`  out  CNT_W  accepted products with sNaN or qNaN set.
- `cnt_inf`  out  CNT_W  accepted products with inf set.
- `cnt_sub`  out  CNT_W  accepted products with subnormal set.

## Operation
- Definitions: accept = `in_valid & in_ready`; drain = `out_valid & out_ready`.
- Quieting, applied at accept:
  - If `in_cls[5]` (sNaN) is set, store `in_p | 16'h0040`.
  - Store the class as sNaN=0, qNaN=1; all other fields pass through unchanged.
  - `in_exc` is stored unchanged; `invalid` is already raised upstream.
- Buffer: a main register (drives the outputs) plus a skid register. States:
  - EMPTY:
    - accept -> ONE.
  - ONE:
    - accept and drain -> ONE, main takes the new entry.
    - accept and no drain -> TWO, new entry goes to skid.
    - drain and no accept -> EMPTY.
  - TWO:
    - drain -> ONE, skid moves to main.
    - No accept is possible in TWO.
- `in_ready` = 1 in EMPTY and ONE, 0 in TWO. It is registered from next-state.
- `out_valid` = 1 in ONE and TWO.
- Payload ordering is strictly FIFO. No entry is dropped or duplicated.
- Statistics are updated only on accept:
  - `cnt_total` +1.
  - `cnt_nan`, `cnt_inf`, `cnt_sub` +1 when the corresponding pre-quieting class bit is set.
  - Each counter saturates at all-ones and does not wrap.
  - `sticky_exc |= in_exc`.
- `clr_stat` in the same cycle as an accept: the clear applies first, then the accepted product's contribution.
  - Result: counters equal 1 or 0 per their condition; sticky equals `in_exc`.
- `clr_stat` does not affect buffer contents or handshake state.

## Timing
- Reset values:
  - State EMPTY; `in_ready`=1; `out_valid`=0.
  - `out_p`=0, `out_exc`=0, `out_cls`=0.
  - `sticky_exc`=0; all counters 0.
- Reset mid-operation discards both buffered entries. The upstream sees `in_ready`=1 the cycle after reset.
- Latency: a product accepted at edge N appears on `out_*` with `out_valid`=1 after edge N, when the buffer was EMPTY.
- Throughput: 1 product/cycle when `out_ready` is held high.
- Stall response:
  - `out_ready` low for one cycle while in ONE with accept -> TWO; `in_ready` falls after that edge.
  - Exactly one extra product is absorbed.
- Statistics outputs reflect an accept one cycle after its edge.
- `out_*` holds stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset, then accept `in_p`=16'h3F80 with cls normal and `out_ready`=1 -> next cycle `out_p`=16'h3F80, `out_valid`=1; `cnt_total`=1; `sticky_exc`=0.
- Accept `in_p`=16'h7F81 with cls sNaN and exc invalid -> `out_p`=16'h7FC1, `out_cls`=6'b010000; `cnt_nan`=1; `sticky_exc`=4'b0010.
- Stream 16'h0001..16'h0005 while `out_ready` is 0 for cycles 2-4:
  - `in_ready` drops after the second accept.
  - The output sequence is exactly 0001..0005 with no loss.
- Accept an overflow product (exc 1000), then `clr_stat` together with an inexact product (exc 0001) -> `sticky_exc`=0001, `cnt_total`=1.
- With `CNT_W`=4, accept 20 inf products -> `cnt_inf`=15 and `cnt_total`=15, with no wrap.
- Assert `rst` while in TWO -> next cycle `out_valid`=0, `in_ready`=1, all counters 0.

Source files
------------

// File: rtl/mul_result_stage.sv
// mul_result_stage
//   Registered output stage after the bfloat16 multiplier. Each product is
//   taken over a valid/ready handshake into a 2-entry skid buffer. The buffer
//   quiets signalling NaNs and keeps sticky exception flags plus saturating
//   result statistics.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. Once valid is raised it is held, with stable data, until that
//   edge. in_ready is a register, so it never depends combinationally on
//   out_ready.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake
//   in_p/in_exc/in_cls    product, {ovf,unf,inv,inx}, {sNaN,qNaN,sub,norm,inf,zero}
//   out_valid/out_ready   downstream handshake
//   out_p/out_exc/out_cls buffered (quieted) entry at the head of the buffer
//   clr_stat          clears sticky flags and counters
//   sticky_exc        OR of accepted in_exc since the last clear
//   cnt_total/nan/inf/sub saturating statistics counters
//   dbgState          buffer FSM state (0 EMPTY, 1 ONE, 2 TWO)
module mul_result_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_p,
  input  logic [3:0]       in_exc,
  input  logic [5:0]       in_cls,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_p,
  output logic [3:0]       out_exc,
  output logic [5:0]       out_cls,
  input  logic             clr_stat,
  output logic [3:0]       sticky_exc,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_nan,
  output logic [CNT_W-1:0] cnt_inf,
  output logic [CNT_W-1:0] cnt_sub,
  output logic [1:0]       dbgState
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stateT;

  typedef struct packed {
    logic [15:0] p;
    logic [3:0]  exc;
    logic [5:0]  cls;
  } entryT;

  stateT state, nextState;
  entryT mainQ, skidQ, newEntry;
  logic  accept, drain;

  logic [CNT_W-1:0] totalNext, nanNext, infNext, subNext;
  logic [3:0]       stickyNext;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v,
                                              input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  always_comb begin
    accept = in_valid & in_ready;
    drain  = out_valid & out_ready;

    // Quieting: set the mantissa MSB and move the class from sNaN to qNaN.
    newEntry.p   = in_cls[5] ? (in_p | 16'h0040) : in_p;
    newEntry.exc = in_exc;
    newEntry.cls = in_cls[5] ? {2'b01, in_cls[3:0]} : in_cls;

    nextState = state;
    case (state)
      EMPTY:   if (accept) nextState = ONE;
      ONE: begin
        if (accept && !drain)      nextState = TWO;
        else if (!accept && drain) nextState = EMPTY;
      end
      TWO:     if (drain) nextState = ONE;
      default: nextState = EMPTY;
    endcase

    // A clear in the same cycle as an accept is applied first, so the
    // accepted product still counts.
    totalNext  = satInc(clr_stat ? '0 : cnt_total, accept);
    nanNext    = satInc(clr_stat ? '0 : cnt_nan, accept & (in_cls[5] | in_cls[4]));
    infNext    = satInc(clr_stat ? '0 : cnt_inf, accept & in_cls[1]);
    subNext    = satInc(clr_stat ? '0 : cnt_sub, accept & in_cls[3]);
    stickyNext = (clr_stat ? 4'b0 : sticky_exc) | (accept ? in_exc : 4'b0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      mainQ      <= '0;
      skidQ      <= '0;
      sticky_exc <= '0;
      cnt_total  <= '0;
      cnt_nan    <= '0;
      cnt_inf    <= '0;
      cnt_sub    <= '0;
    end else begin
      state     <= nextState;
      in_ready  <= (nextState != TWO);
      out_valid <= (nextState != EMPTY);

      case (state)
        EMPTY: if (accept) mainQ <= newEntry;
        ONE: begin
          // Main only takes a new entry once its current one has left.
          if (accept && drain)  mainQ <= newEntry;
          if (accept && !drain) skidQ <= newEntry;
        end
        TWO:   if (drain) mainQ <= skidQ;
        default: ;
      endcase

      sticky_exc <= stickyNext;
      cnt_total  <= totalNext;
      cnt_nan    <= nanNext;
      cnt_inf    <= infNext;
      cnt_sub    <= subNext;
    end
  end

  assign out_p    = mainQ.p;
  assign out_exc  = mainQ.exc;
  assign out_cls  = mainQ.cls;
  assign dbgState = state;

endmodule

// File: tb/tb_mul_result_stage.sv
module tb_mul_result_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A (default counter width) ----------------
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] in_p = '0;
  logic [3:0]  in_exc = '0;
  logic [5:0]  in_cls = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] out_p;
  logic [3:0]  out_exc;
  logic [5:0]  out_cls;
  logic        clr_stat = 1'b0;
  logic [3:0]  sticky_exc;
  logic [15:0] cnt_total, cnt_nan, cnt_inf, cnt_sub;
  logic [1:0]  dbg_state;

  mul_result_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p(in_p), .in_exc(in_exc), .in_cls(in_cls),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_exc(out_exc), .out_cls(out_cls),
    .clr_stat(clr_stat), .sticky_exc(sticky_exc),
    .cnt_total(cnt_total), .cnt_nan(cnt_nan), .cnt_inf(cnt_inf), .cnt_sub(cnt_sub),
    .dbgState(dbg_state)
  );

  // ---------------- DUT B (4-bit counters, saturation) ----------------
  logic        b_in_valid = 1'b0, b_in_ready;
  logic [15:0] b_in_p = '0;
  logic [3:0]  b_in_exc = '0;
  logic [5:0]  b_in_cls = '0;
  logic        b_out_valid;
  logic [15:0] b_out_p;
  logic [3:0]  b_out_exc;
  logic [5:0]  b_out_cls;
  logic [3:0]  b_sticky_exc;
  logic [3:0]  b_cnt_total, b_cnt_nan, b_cnt_inf, b_cnt_sub;
  logic [1:0]  b_dbg_state;

  mul_result_stage #(.CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_p(b_in_p), .in_exc(b_in_exc), .in_cls(b_in_cls),
    .out_valid(b_out_valid), .out_ready(1'b1),
    .out_p(b_out_p), .out_exc(b_out_exc), .out_cls(b_out_cls),
    .clr_stat(1'b0), .sticky_exc(b_sticky_exc),
    .cnt_total(b_cnt_total), .cnt_nan(b_cnt_nan), .cnt_inf(b_cnt_inf), .cnt_sub(b_cnt_sub),
    .dbgState(b_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [25:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every drained entry against the head of the queue.
  initial begin
    logic [25:0] exp_e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL out_unexpected: got p=0x%0h with no entry expected", out_p);
        end else begin
          exp_e = exp_q.pop_front();
          if ({out_p, out_exc, out_cls} !== exp_e) begin
            fails++;
            $display("FAIL out_entry: got p=%h exc=%b cls=%b, expected p=%h exc=%b cls=%b",
                     out_p, out_exc, out_cls, exp_e[25:10], exp_e[9:6], exp_e[5:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drives one product and returns just before the edge that accepts it.
  task automatic send(input logic [15:0] p, input logic [3:0] exc, input logic [5:0] cls,
                      input logic [15:0] exp_p, input logic [5:0] exp_cls, input logic clr);
    int waited = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_p = p; in_exc = exc; in_cls = cls; clr_stat = clr;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end else begin
      exp_q.push_back({exp_p, exc, exp_cls});
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; clr_stat = 1'b0;
  endtask

  task automatic wait_drained();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_complete", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_payload", {out_p, out_exc, out_cls}, 0);
    check("rst_sticky", sticky_exc, 0);
    check("rst_counters", {cnt_total, cnt_nan}, 0);
    check("rst_counters2", {cnt_inf, cnt_sub}, 0);

    // plain normal product, one-cycle latency
    out_ready = 1'b1;
    send(16'h3F80, 4'b0000, 6'b000100, 16'h3F80, 6'b000100, 1'b0);
    idle();
    check("lat_out_valid", out_valid, 1);
    check("lat_out_p", out_p, 16'h3F80);
    check("lat_cnt_total", cnt_total, 1);
    check("lat_sticky", sticky_exc, 0);

    // sNaN gets quieted
    send(16'h7F81, 4'b0010, 6'b100000, 16'h7FC1, 6'b010000, 1'b0);
    idle();
    check("snan_out_p", out_p, 16'h7FC1);
    check("snan_out_cls", out_cls, 6'b010000);
    check("snan_cnt_nan", cnt_nan, 1);
    check("snan_sticky", sticky_exc, 4'b0010);
    check("snan_cnt_total", cnt_total, 2);
    wait_drained();

    // stream 1..5 with a three-cycle downstream stall
    fork
      begin
        for (int i = 1; i <= 5; i++)
          send(16'(i), 4'b0000, 6'b000100, 16'(i), 6'b000100, 1'b0);
        idle();
      end
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("stall_in_ready_low", in_ready, 0);
        check("stall_state_two", dbg_state, 2);
        @(posedge clk); #1;
        check("stall_out_hold", out_p, 16'h0001);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drained();

    // clear together with an accept
    send(16'h4000, 4'b1000, 6'b000100, 16'h4000, 6'b000100, 1'b0);
    send(16'h3F81, 4'b0001, 6'b000100, 16'h3F81, 6'b000100, 1'b1);
    idle();
    check("clr_sticky", sticky_exc, 4'b0001);
    check("clr_cnt_total", cnt_total, 1);
    check("clr_cnt_nan", cnt_nan, 0);
    wait_drained();

    // saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      b_in_valid = 1'b1; b_in_p = 16'h7F80; b_in_cls = 6'b000010;
      check("sat_b_in_ready", b_in_ready, 1);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    check("sat_cnt_inf", b_cnt_inf, 15);
    check("sat_cnt_total", b_cnt_total, 15);

    // reset while holding two entries
    out_ready = 1'b0;
    send(16'h1111, 4'b0100, 6'b001000, 16'h1111, 6'b001000, 1'b0);
    send(16'h2222, 4'b0000, 6'b000100, 16'h2222, 6'b000100, 1'b0);
    idle();
    check("pre_rst_state_two", dbg_state, 2);
    check("pre_rst_cnt_sub", cnt_sub, 1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_counters", {cnt_total, cnt_nan, cnt_inf, cnt_sub}, 0);
    check("mid_rst_sticky", sticky_exc, 0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("end_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
